// File: rtl/ring_link_tx.sv
// Credit-based ring link transmitter: pops the local fall-through FIFO, registers flits onto the link.
// Latency: 1 cycle pop-to-link. Backpressure: never pops without a downstream credit.
module ring_link_tx #(
  parameter int WIDTH   = 8,
  parameter int CREDITS = 2,
  parameter int CRD_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iEn,
  input  logic             iFifoEmpty,
  input  logic [WIDTH-1:0] iFifoDat,
  output logic             oFifoRdEn,
  output logic             oLinkVld,
  output logic [WIDTH-1:0] oLinkDat,
  input  logic             iLinkCrd,
  output logic [CRD_W-1:0] oCrdCnt,
  output logic             oIdle,
  output logic             oCrdErr
);

  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDITS);
  localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CRD_W-1:0] crd_cnt;
  logic             pop;

  // Only the registered count gates a pop; a credit arriving this cycle is usable next cycle.
  assign pop       = (state == RUN) && !iFifoEmpty && (crd_cnt != '0);
  assign oFifoRdEn = pop;
  assign oCrdCnt   = crd_cnt;
  assign oIdle     = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iEn) state_nxt = RUN;
      RUN:     if (!iEn) state_nxt = DRAIN;
      DRAIN: begin
        if (iEn)                      state_nxt = RUN;
        else if (crd_cnt == CRD_FULL) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      crd_cnt  <= CRD_FULL;
      oLinkVld <= 1'b0;
      oLinkDat <= '0;
      oCrdErr  <= 1'b0;
    end else begin
      state    <= state_nxt;
      oLinkVld <= pop;
      if (pop) oLinkDat <= iFifoDat;
      case ({pop, iLinkCrd})
        2'b10: crd_cnt <= crd_cnt - CRD_ONE;
        2'b01: begin
          // A credit beyond the receiver depth means the peer is out of sync; saturate and flag it.
          if (crd_cnt == CRD_FULL) oCrdErr <= 1'b1;
          else                     crd_cnt <= crd_cnt + CRD_ONE;
        end
        default: crd_cnt <= crd_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_link_tx.sv
// Directed bench for ring_link_tx: vector table for credit flow plus hand sequences for drain/overflow/reset.
module tb_ring_link_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic       iEn;
  logic       iFifoEmpty;
  logic [7:0] iFifoDat;
  logic       oFifoRdEn;
  logic       oLinkVld;
  logic [7:0] oLinkDat;
  logic       iLinkCrd;
  logic [1:0] oCrdCnt;
  logic       oIdle;
  logic       oCrdErr;

  always #5 clk = ~clk;

  ring_link_tx #(.WIDTH(8), .CREDITS(2)) dut (
    .clk(clk), .rst(rst), .iEn(iEn), .iFifoEmpty(iFifoEmpty), .iFifoDat(iFifoDat),
    .oFifoRdEn(oFifoRdEn), .oLinkVld(oLinkVld), .oLinkDat(oLinkDat), .iLinkCrd(iLinkCrd),
    .oCrdCnt(oCrdCnt), .oIdle(oIdle), .oCrdErr(oCrdErr)
  );

  typedef struct {
    logic       en;
    logic       crd;
    logic       rd;
    logic       vld;
    logic [7:0] dat;
    logic [1:0] cnt;
    logic       idle;
  } vec_t;

  vec_t       tbl[12];
  logic [7:0] q[$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Fall-through FIFO model feeding the DUT
  task automatic upd();
    iFifoEmpty = (q.size() == 0);
    iFifoDat   = (q.size() == 0) ? 8'h00 : q[0];
  endtask

  task automatic tick();
    logic pp;
    #1;
    pp = oFifoRdEn;
    @(posedge clk);
    #1;
    if (pp && q.size() != 0) void'(q.pop_front());
    upd();
  endtask

  task automatic chk_rd(input string name, input logic exp);
    #1;
    chk(name, oFifoRdEn, exp);
  endtask

  initial begin
    // en, crd | rd (pre-edge), vld, dat, cnt, idle (post-edge)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 2'd1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 2'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 2'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 2'd0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 2'd1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 2'd1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 2'd1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 2'd2, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 2'd2, 1'b0};

    // Reset held with enable and a non-empty FIFO
    rst = 1'b1; iEn = 1'b1; iLinkCrd = 1'b0;
    q.push_back(8'hEE); upd();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rd", oFifoRdEn, 1'b0);
      chk("rst_vld", oLinkVld, 1'b0);
      chk("rst_dat", oLinkDat, 8'h00);
      chk("rst_cnt", oCrdCnt, 2'd2);
      chk("rst_idle", oIdle, 1'b1);
      chk("rst_err", oCrdErr, 1'b0);
    end
    rst = 1'b0; iEn = 1'b0;
    q.delete();
    for (int i = 1; i <= 5; i++) q.push_back(8'(i));
    upd();

    // Credit exhaustion, single return, then steady-state with continuous credits
    for (int i = 0; i < 12; i++) begin
      iEn = tbl[i].en; iLinkCrd = tbl[i].crd;
      chk_rd($sformatf("vec%0d_rd", i), tbl[i].rd);
      tick();
      chk($sformatf("vec%0d_vld", i), oLinkVld, tbl[i].vld);
      chk($sformatf("vec%0d_dat", i), oLinkDat, tbl[i].dat);
      chk($sformatf("vec%0d_cnt", i), oCrdCnt, tbl[i].cnt);
      chk($sformatf("vec%0d_idle", i), oIdle, tbl[i].idle);
      chk($sformatf("vec%0d_err", i), oCrdErr, 1'b0);
    end
    iLinkCrd = 1'b0;

    // Drain: last RUN pop still reaches the link, no pops in DRAIN
    rst = 1'b1; tick(); rst = 1'b0;
    q.push_back(8'h10); q.push_back(8'h11); q.push_back(8'h12); upd();
    iEn = 1'b1; tick();
    chk_rd("drain_pop0", 1'b1); tick();
    chk("drain_dat0", oLinkDat, 8'h10);
    iEn = 1'b0;
    chk_rd("drain_lastpop", 1'b1); tick();
    chk("drain_last_vld", oLinkVld, 1'b1);
    chk("drain_last_dat", oLinkDat, 8'h11);
    chk("drain_cnt0", oCrdCnt, 2'd0);
    for (int i = 0; i < 3; i++) begin
      chk_rd("drain_nopop", 1'b0); tick();
      chk("drain_vld", oLinkVld, 1'b0);
      chk("drain_idle", oIdle, 1'b0);
    end
    iLinkCrd = 1'b1; tick();
    chk("drain_cnt1", oCrdCnt, 2'd1);
    tick();
    chk("drain_cnt2", oCrdCnt, 2'd2);
    chk("drain_idle_late", oIdle, 1'b0);
    iLinkCrd = 1'b0; tick();
    chk("drain_to_idle", oIdle, 1'b1);
    chk("drain_err", oCrdErr, 1'b0);

    // Re-raising enable in DRAIN goes straight back to RUN
    iEn = 1'b1; tick();
    chk_rd("rerun_pop12", 1'b1); tick();
    chk("rerun_dat12", oLinkDat, 8'h12);
    chk("rerun_cnt1", oCrdCnt, 2'd1);
    iEn = 1'b0; tick();
    chk("rerun_drain_idle", oIdle, 1'b0);
    iEn = 1'b1;
    chk_rd("rerun_drain_nopop", 1'b0); tick();
    q.push_back(8'h13); upd();
    chk_rd("rerun_pop13", 1'b1); tick();
    chk("rerun_vld13", oLinkVld, 1'b1);
    chk("rerun_dat13", oLinkDat, 8'h13);
    chk("rerun_cnt0", oCrdCnt, 2'd0);

    // Overflow: extra credit in IDLE saturates and sets the sticky error
    iEn = 1'b0; iLinkCrd = 1'b1; tick(); tick();
    iLinkCrd = 1'b0; tick();
    chk("ovf_idle", oIdle, 1'b1);
    chk("ovf_pre_err", oCrdErr, 1'b0);
    iLinkCrd = 1'b1; tick();
    chk("ovf_cnt", oCrdCnt, 2'd2);
    chk("ovf_err", oCrdErr, 1'b1);
    iLinkCrd = 1'b0; tick(); tick();
    chk("ovf_err_sticky", oCrdErr, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("ovf_err_rst", oCrdErr, 1'b0);

    // Empty FIFO, then a single late write
    iEn = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      chk_rd("empty_rd", 1'b0); tick();
      chk("empty_vld", oLinkVld, 1'b0);
      chk("empty_cnt", oCrdCnt, 2'd2);
    end
    q.push_back(8'hA5); upd();
    chk_rd("a5_rd", 1'b1); tick();
    chk("a5_vld", oLinkVld, 1'b1);
    chk("a5_dat", oLinkDat, 8'hA5);
    chk("a5_cnt", oCrdCnt, 2'd1);
    tick();
    chk("a5_vld_off", oLinkVld, 1'b0);
    chk("a5_dat_hold", oLinkDat, 8'hA5);

    // Reset mid-stream discards in-flight state
    q.push_back(8'h20); q.push_back(8'h21); upd();
    tick();
    chk("mid_vld", oLinkVld, 1'b1);
    chk("mid_cnt", oCrdCnt, 2'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_vld", oLinkVld, 1'b0);
    chk("mid_rst_dat", oLinkDat, 8'h00);
    chk("mid_rst_cnt", oCrdCnt, 2'd2);
    chk("mid_rst_idle", oIdle, 1'b1);
    chk("mid_rst_rd", oFifoRdEn, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ring_link_tx.md
# ring_link_tx

Credit-based ring link transmitter: drains flits from the local two-register FIFO (the reader side of that FIFO) and drives them onto a point-to-point ring link toward the downstream node's input FIFO. It never sends a flit without a downstream credit. Credits are returned one per flit that the receiver pops. It sits at the egress of each ring node, between the node's output FIFO and the link wires.

## Interface
Parameters:
- WIDTH, 8, flit data width in bits.
- CREDITS, 2, initial credit count; equals the downstream receive FIFO depth.
- CRD_W, $clog2(CREDITS+1), credit counter width (derived; do not override).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- iEn  in  1  transmit enable: level-sensitive request to run.
- iFifoEmpty  in  1  local FIFO empty flag.
- iFifoDat  in  WIDTH  local FIFO head data; valid whenever iFifoEmpty=0 (fall-through).
- oFifoRdEn  out  WIDTH-independent 1  pop strobe to the local FIFO; the head is consumed at the same clock edge.
- oLinkVld  out  1  flit valid on link, registered.
- oLinkDat  out  WIDTH  flit data on link, registered.
- iLinkCrd  in  1  credit return pulse from downstream; 1 cycle = 1 credit.
- oCrdCnt  out  CRD_W  current available credits, registered.
- oIdle  out  1  1 when in IDLE with all credits home.
- oCrdErr  out  1  sticky: a credit was returned while the count was already CREDITS.

## Operation
- FSM states:
  - IDLE: no pops. iEn=1 → RUN.
  - RUN: pop and send. iEn=0 → DRAIN.
  - DRAIN: no pops; wait for outstanding credits. iEn=1 → RUN. Otherwise crdCnt==CREDITS → IDLE.
- Pop condition (combinational): oFifoRdEn = (state==RUN) & !iFifoEmpty & (crdCnt!=0). The decision uses only the registered crdCnt; a credit arriving in the same cycle is not usable until the next cycle.
- Send: on a pop edge, oLinkVld<=1 and oLinkDat<=iFifoDat. On any other edge, oLinkVld<=0 and oLinkDat holds its last value.
- Credit arithmetic, per edge:
  - pop only → crdCnt−1.
  - iLinkCrd only → crdCnt+1.
  - both → unchanged.
  - neither → unchanged.
- Credit overflow: iLinkCrd with crdCnt==CREDITS and no pop → crdCnt stays CREDITS (saturates) and oCrdErr<=1. oCrdErr clears only on rst.
- The count never underflows, because a pop requires crdCnt≠0.
- oIdle = (state==IDLE). IDLE is entered from DRAIN only with all credits home; after reset the count is already full.
- iEn deasserting mid-stream: the flit popped in the last RUN cycle is still driven on the link in the following cycle. No pop is issued in DRAIN.

## Timing
- Reset values:
  - state=IDLE.
  - crdCnt=CREDITS.
  - oLinkVld=0, oLinkDat=0.
  - oFifoRdEn=0.
  - oIdle=1, oCrdErr=0.
- rst asserted mid-operation: all of the above apply at the next edge. In-flight flits and outstanding credits are discarded; the downstream node must be reset together.
- iEn=1 in IDLE → RUN after 1 edge. The first pop is possible in the cycle after iEn is sampled high.
- Pop-to-link latency: 1 cycle. oLinkVld is high in the cycle after oFifoRdEn=1.
- Throughput: 1 flit/cycle while credits last. With CREDITS=2 and a 2-cycle credit round trip, the sustained rate is 1 flit/cycle; longer round trips throttle to CREDITS per round trip.
- DRAIN→IDLE: the edge after crdCnt reaches CREDITS. oIdle rises 1 cycle later.

## Test plan
- Reset: hold rst=1 for 3 cycles with iEn=1 and iFifoEmpty=0 → oFifoRdEn=0, oLinkVld=0, oCrdCnt=2, oIdle=1, oCrdErr=0 throughout.
- Credit exhaustion: iEn=1, FIFO holds 0x01..0x05, iLinkCrd=0.
  - Exactly 2 pops occur; the link carries 0x01 then 0x02 on consecutive cycles.
  - oCrdCnt steps 2→1→0 and stays 0; no further oLinkVld.
- Credit return/simultaneity: from crdCnt=0, pulse iLinkCrd once.
  - The next cycle pops 0x03; the count goes 0→1→0.
  - Then hold iLinkCrd=1 every cycle with the FIFO non-empty → 1 flit/cycle, with oCrdCnt constant.
- Drain: after sending 2 flits (crdCnt=0), drop iEn.
  - The FSM is in DRAIN with no pops even though the FIFO is non-empty.
  - Return 2 credits → oCrdCnt=2, then IDLE, with oIdle=1 one cycle later.
  - Re-raising iEn in DRAIN returns to RUN without waiting.
- Overflow: in IDLE with crdCnt=2, pulse iLinkCrd → oCrdCnt stays 2 and oCrdErr=1, held until rst.
- Empty FIFO: iEn=1, iFifoEmpty=1 for 10 cycles → no pops, oLinkVld=0, oCrdCnt=2. Write 0xA5 → 0xA5 appears on oLinkDat with oLinkVld=1 exactly 1 cycle after the pop.
